// File: rtl/argmax_sched_pkg.sv
// Shared types for the argmax scheduler: FSM state encoding and drain-length formula.
package argmax_sched_pkg;

    typedef enum logic [2:0] {
        DRAIN = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Cycles needed to flush any job still running in the un-resettable argmax unit.
    function automatic int drain_cyc(input int addr_data_delay, input int input_elts);
        return 2 * addr_data_delay + input_elts + 2;
    endfunction

endpackage

// File: rtl/argmax_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                        = 1'b1;
                idx                        = IW'((int'(ptr) + k) % N);
                onehot[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/argmax_sched.sv
// Round-robin scheduler sharing one argmax unit between N_REQ requesters.
// Define ARGMAX_SCHED_TIMEOUT_EN to add a WAIT watchdog that reports rsp_err and re-drains.
module argmax_sched
    import argmax_sched_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int PORT_W          = 8,
    parameter int INPUT_ELTS      = 10,
    parameter int ADDR_DATA_DELAY = 2,
    parameter int BASE_W          = 16,
    parameter int TIMEOUT_CYC     = 64,
    localparam int IADDR_W        = $clog2(INPUT_ELTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*BASE_W-1:0] req_base,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [IADDR_W-1:0]      rsp_idx,
    output logic                    rsp_err,
    output logic                    am_start,
    input  logic                    am_done,
    input  logic [IADDR_W-1:0]      am_addri,
    input  logic [IADDR_W-1:0]      am_maxidx,
    output logic [BASE_W-1:0]       mem_addr,
    output logic [2:0]              dbg_state
);

    localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DRAIN_CYC = drain_cyc(ADDR_DATA_DELAY, INPUT_ELTS);
    localparam int DCTR_W    = $clog2(DRAIN_CYC + 1);

    // PORT_W belongs to the external argmax; the watchdog must outlast a full job.
    if (PORT_W < 1 || TIMEOUT_CYC <= DRAIN_CYC) begin : g_param_range
    end

    state_t              state_q, state_d;
    logic [DCTR_W-1:0]   drain_q, drain_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [IADDR_W-1:0]  rsp_idx_q, rsp_idx_d;
    logic                am_start_q, am_start_d;

    logic [N_REQ-1:0]    pick_onehot;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;

`ifdef ARGMAX_SCHED_TIMEOUT_EN
    localparam int WCTR_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCTR_W-1:0]   wait_q, wait_d;
    logic                rsp_err_q, rsp_err_d;
`endif

    rr_pick #(.N(N_REQ), .IW(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        base_d      = base_q;
        rsp_valid_d = rsp_valid_q;
        rsp_idx_d   = rsp_idx_q;
        am_start_d  = am_start_q;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
        wait_d      = wait_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            DRAIN: begin
                if (drain_q == DCTR_W'(DRAIN_CYC - 1)) begin
                    drain_d = '0;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            IDLE: begin
                if (pick_any) begin
                    gnt_d      = pick_onehot;
                    owner_d    = pick_idx;
                    base_d     = req_base[int'(pick_idx) * BASE_W +: BASE_W];
                    am_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                am_start_d = 1'b0;
                state_d    = WAIT;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
                wait_d     = '0;
`endif
            end
            WAIT: begin
                // A real done always takes priority over the watchdog.
                if (am_done) begin
                    rsp_idx_d   = am_maxidx;
                    rsp_valid_d = gnt_q;
                    state_d     = RESP;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (wait_q == WCTR_W'(TIMEOUT_CYC - 1)) begin
                    rsp_idx_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = gnt_q;
                    state_d     = RESP;
                end else begin
                    wait_d      = wait_q + 1'b1;
`endif
                end
            end
            RESP: begin
                gnt_d       = '0;
                rsp_valid_d = '0;
                ptr_d       = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d     = IDLE;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
                if (rsp_err_q) state_d = DRAIN;
`endif
            end
            default: state_d = DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DRAIN;
            drain_q     <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            base_q      <= '0;
            rsp_valid_q <= '0;
            rsp_idx_q   <= '0;
            am_start_q  <= 1'b0;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
            wait_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            base_q      <= base_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            am_start_q  <= am_start_d;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
            wait_q      <= wait_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_idx   = rsp_idx_q;
    assign am_start  = am_start_q;
    assign mem_addr  = base_q + BASE_W'(am_addri);
    assign dbg_state = state_q;
`ifdef ARGMAX_SCHED_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_argmax_sched.sv
// Bench for argmax_sched: behavioural argmax + 64-entry memory, a cycle checker, and directed jobs.
module tb_argmax_sched;
    localparam int N_REQ           = 4;
    localparam int PORT_W          = 8;
    localparam int INPUT_ELTS      = 10;
    localparam int ADDR_DATA_DELAY = 2;
    localparam int BASE_W          = 16;
    localparam int TIMEOUT_CYC     = 64;
    localparam int IADDR_W         = $clog2(INPUT_ELTS);
    localparam int DRAIN_CYC       = 2 * ADDR_DATA_DELAY + INPUT_ELTS + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*BASE_W-1:0] req_base = '0;
    logic [N_REQ-1:0]        gnt, rsp_valid;
    logic [IADDR_W-1:0]      rsp_idx;
    logic                    rsp_err, am_start;
    logic                    am_done;
    logic [IADDR_W-1:0]      am_addri, am_maxidx;
    logic [BASE_W-1:0]       mem_addr;
    logic [2:0]              dbg_state;

    always #5 clk = ~clk;

    argmax_sched #(
        .N_REQ(N_REQ), .PORT_W(PORT_W), .INPUT_ELTS(INPUT_ELTS),
        .ADDR_DATA_DELAY(ADDR_DATA_DELAY), .BASE_W(BASE_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_base(req_base),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_err(rsp_err),
        .am_start(am_start), .am_done(am_done), .am_addri(am_addri),
        .am_maxidx(am_maxidx), .mem_addr(mem_addr), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory and argmax unit ----------------
    logic [PORT_W-1:0] mem [64];
    logic              stub_mode = 1'b0;
    logic [BASE_W-1:0] addr_log [INPUT_ELTS];
    logic [PORT_W-1:0] am_best;
    int                am_best_k;

    initial begin
        am_done = 1'b0; am_addri = '0; am_maxidx = '0;
        forever begin
            @(negedge clk);
            if (rst_n && am_start && !stub_mode) begin
                for (int k = 0; k < INPUT_ELTS; k++) begin
                    @(posedge clk); #1 am_addri = IADDR_W'(k);
                    @(negedge clk); addr_log[k] = mem_addr;
                end
                repeat (ADDR_DATA_DELAY) @(posedge clk);
                am_best = mem[addr_log[0][5:0]]; am_best_k = 0;
                for (int k = 1; k < INPUT_ELTS; k++)
                    if (mem[addr_log[k][5:0]] > am_best) begin
                        am_best = mem[addr_log[k][5:0]]; am_best_k = k;
                    end
                #1 am_done = 1'b1; am_maxidx = IADDR_W'(am_best_k);
                @(posedge clk); #1 am_done = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++)
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        return -1;
    endfunction

    function automatic logic [IADDR_W-1:0] model_argmax(input logic [BASE_W-1:0] b);
        logic [PORT_W-1:0] bv;
        logic [BASE_W-1:0] a;
        int bk;
        bv = mem[b[5:0]]; bk = 0;
        for (int k = 1; k < INPUT_ELTS; k++) begin
            a = b + BASE_W'(k);
            if (mem[a[5:0]] > bv) begin bv = mem[a[5:0]]; bk = k; end
        end
        return IADDR_W'(bk);
    endfunction

    int                 exp_own_q [$];
    logic [IADDR_W-1:0] exp_idx_q [$];
    logic [N_REQ-1:0]   gnt_hist [$];
    logic [IADDR_W-1:0] idx_hist [$];
    logic [N_REQ-1:0]   prev_req, prev_gnt, prev_rsp;
    logic [N_REQ*BASE_W-1:0] prev_base;
    logic               prev_idle;
    int model_ptr, quiet, cyc, start_cyc, rsp_count, grant_total;
    int pick, own;
    logic [N_REQ-1:0]   exp_g;
    logic [IADDR_W-1:0] e_idx;
    logic [N_REQ-1:0]   last_rsp_valid;
    logic [IADDR_W-1:0] last_rsp_idx;
    logic               last_rsp_err;

    initial begin
        rsp_count = 0; grant_total = 0; prev_idle = 1'b0; quiet = 0;
        prev_gnt = '0; prev_rsp = '0; prev_req = '0; prev_base = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_own_q.delete(); exp_idx_q.delete(); gnt_hist.delete(); idx_hist.delete();
            model_ptr = 0; quiet = DRAIN_CYC + 1; cyc = 0;
            prev_idle = 1'b0; prev_gnt = '0; prev_rsp = '0;
        end else begin
            cyc++;
            if (quiet > 0) begin
                chk("drain_no_gnt", gnt, 0);
                quiet--;
            end
            if (prev_idle) begin
                pick  = model_pick(prev_req, model_ptr);
                exp_g = (pick >= 0) ? (N_REQ'(1) << pick) : '0;
                chk("arb_gnt", gnt, exp_g);
                chk("arb_am_start", am_start, (exp_g != 0));
                if (pick >= 0) begin
                    exp_own_q.push_back(pick);
                    exp_idx_q.push_back(model_argmax(prev_base[pick*BASE_W +: BASE_W]));
                    gnt_hist.push_back(gnt);
                    grant_total++;
                    start_cyc = cyc;
                end
            end else begin
                chk("am_start_quiet", am_start, 0);
                if (prev_gnt != 0 && prev_rsp == 0) chk("gnt_held", gnt, prev_gnt);
                if (prev_rsp != 0) chk("gnt_release", gnt, 0);
            end
            if (prev_rsp != 0) chk("rsp_one_cycle", rsp_valid, 0);
            if (rsp_valid != 0) begin
                if (exp_own_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    own   = exp_own_q.pop_front();
                    e_idx = exp_idx_q.pop_front();
                    chk("rsp_valid_owner", rsp_valid, N_REQ'(1) << own);
                    chk("rsp_gnt_match", gnt, N_REQ'(1) << own);
                    chk("rsp_idx", rsp_idx, stub_mode ? '0 : e_idx);
                    chk("rsp_err", rsp_err, stub_mode);
                    if (stub_mode) chk("timeout_latency", cyc - start_cyc, TIMEOUT_CYC + 1);
                    model_ptr = (own + 1) % N_REQ;
                    quiet = stub_mode ? DRAIN_CYC + 1 : 1;
                end
                rsp_count++;
                last_rsp_valid = rsp_valid; last_rsp_idx = rsp_idx; last_rsp_err = rsp_err;
                idx_hist.push_back(rsp_idx);
            end
            prev_idle = (quiet == 0) && (gnt == 0);
            prev_gnt  = gnt;
            prev_rsp  = rsp_valid;
        end
        prev_req  = req;
        prev_base = req_base;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (rsp_count < n && t < 300) begin step(); t++; end
        if (rsp_count < n) chk("wait_rsp_timeout", rsp_count, n);
    endtask

    task automatic wait_gnt();
        int t;
        t = 0;
        while (gnt == 0 && t < 100) begin step(); t++; end
        if (gnt == 0) chk("wait_gnt_timeout", gnt, 1);
    endtask

    logic [BASE_W-1:0] exp_addr [INPUT_ELTS];
    int c, g0, r0, t;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = PORT_W'(i % 5);
        mem[7] = 8'd200; mem[13] = 8'd210; mem[20] = 8'd220; mem[39] = 8'd230;
        exp_addr = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000,
                     16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};

        repeat (3) @(posedge clk);
        step();
        chk("reset_gnt", gnt, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_idx", rsp_idx, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_am_start", am_start, 0);

        // 1: request right after reset waits out the drain
        drive_edge();
        rst_n = 1'b1; req = 4'b0001; req_base[0*BASE_W +: BASE_W] = 16'd0;
        step();
        c = 0;
        while (gnt == 0 && c < 100) begin step(); c++; end
        chk("t1_first_gnt_cycle", c, DRAIN_CYC + 1);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_am_start", am_start, 1);
        wait_rsp(1);
        chk("t1_rsp_valid", last_rsp_valid, 4'b0001);
        chk("t1_rsp_idx", last_rsp_idx, 7);
        chk("t1_rsp_err", last_rsp_err, 0);
        drive_edge(); req = '0;

        // 3: wrapping base address
        repeat (3) step();
        drive_edge(); req_base[2*BASE_W +: BASE_W] = 16'hFFFC; req = 4'b0100;
        wait_rsp(2);
        drive_edge(); req = '0;
        chk("t3_rsp_idx", last_rsp_idx, 8);
        for (int k = 0; k < INPUT_ELTS; k++) chk("t3_mem_addr", addr_log[k], exp_addr[k]);

        // 4: request dropped mid-job still gets its response, no regrant
        repeat (3) step();
        drive_edge(); req_base[1*BASE_W +: BASE_W] = 16'd10; req = 4'b0010;
        wait_gnt();
        repeat (3) step();
        drive_edge(); req = '0;
        wait_rsp(3);
        chk("t4_rsp_valid", last_rsp_valid, 4'b0010);
        chk("t4_rsp_idx", last_rsp_idx, 3);
        g0 = grant_total;
        repeat (30) step();
        chk("t4_no_regrant", grant_total - g0, 0);

        // 5: reset during WAIT aborts silently, then 2: full rotation from ptr 0
        drive_edge();
        req_base[2*BASE_W +: BASE_W] = 16'd20; req_base[3*BASE_W +: BASE_W] = 16'd30;
        req = 4'b1111;
        wait_gnt();
        chk("t5_gnt_before_reset", gnt, 4'b0100);
        repeat (4) step();
        r0 = rsp_count;
        drive_edge(); rst_n = 1'b0;
        drive_edge(); rst_n = 1'b1;
        step();
        chk("t5_gnt_after_reset", gnt, 0);
        chk("t5_rsp_after_reset", rsp_valid, 0);
        t = 0;
        while (gnt_hist.size() < 5 && t < 600) begin step(); t++; end
        chk("t5_grant_count", gnt_hist.size(), 5);
        chk("t5_no_aborted_rsp", rsp_count - r0, 4);
        if (gnt_hist.size() >= 5) begin
            chk("t2_gnt0", gnt_hist[0], 4'b0001);
            chk("t2_gnt1", gnt_hist[1], 4'b0010);
            chk("t2_gnt2", gnt_hist[2], 4'b0100);
            chk("t2_gnt3", gnt_hist[3], 4'b1000);
            chk("t2_gnt4", gnt_hist[4], 4'b0001);
        end
        if (idx_hist.size() >= 4) begin
            chk("t2_idx0", idx_hist[0], 7);
            chk("t2_idx1", idx_hist[1], 3);
            chk("t2_idx2", idx_hist[2], 0);
            chk("t2_idx3", idx_hist[3], 9);
        end
        drive_edge(); req = '0;
        wait_rsp(r0 + 5);
        repeat (5) step();

`ifdef ARGMAX_SCHED_TIMEOUT_EN
        // 6: argmax never answers -> watchdog response, then drain
        stub_mode = 1'b1;
        drive_edge(); req = 4'b0001; req_base[0*BASE_W +: BASE_W] = 16'd0;
        r0 = rsp_count;
        wait_rsp(r0 + 1);
        chk("t6_rsp_valid", last_rsp_valid, 4'b0001);
        chk("t6_rsp_err", last_rsp_err, 1);
        chk("t6_rsp_idx", last_rsp_idx, 0);
        drive_edge(); req = '0; stub_mode = 1'b0;
        drive_edge(); req = 4'b0001;
        wait_rsp(r0 + 2);
        chk("t6_recover_idx", last_rsp_idx, 7);
        chk("t6_recover_err", last_rsp_err, 0);
        drive_edge(); req = '0;
        repeat (5) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
